// File: rtl/panel_pkg.sv
// Shared constants for the switch/LED front panel.
//   SYSCLK_HZ                - system clock frequency
//   DEBOUNCE_MS              - switch settle time
//   DEBOUNCE_CYCLES_DEFAULT  - settle time expressed in sysclk cycles
//   SW_WIDTH                 - number of slide switches on the board
//   cnt_width()              - stability counter width for a given cycle count
package panel_pkg;

    localparam int unsigned SYSCLK_HZ               = 125000000;
    localparam int unsigned DEBOUNCE_MS             = 10;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (SYSCLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int unsigned SW_WIDTH                = 2;

    // $clog2(1) is 0, but the counter still needs one bit to exist.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter and stable level.
// Ports:
//   sysclk        - system clock, rising edge
//   rst           - synchronous active-high reset
//   sw_i          - raw asynchronous switch pin
//   stable_o      - debounced level (registered)
//   stable_next_o - level stable_o takes at the next edge
//   update_o      - high in the cycle where stable_o is about to change
//   rise_o        - registered one-cycle pulse on an accepted 0->1 change
//   fall_o        - registered one-cycle pulse on an accepted 1->0 change
module sw_debounce_bit
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic sysclk,
    input  logic rst,
    input  logic sw_i,
    output logic stable_o,
    output logic stable_next_o,
    output logic update_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s1_d;
    logic            s2_q, s2_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            stable_q, stable_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            update;

    always_comb begin
        s1_d     = sw_i;
        s2_d     = s1_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        update   = 1'b0;
        if (s2_q == stable_q) begin
            // Any cycle back at the stable level restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            stable_d = s2_q;
            cnt_d    = '0;
            update   = 1'b1;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o      = stable_q;
    assign stable_next_o = stable_d;
    assign update_o      = update;
    assign rise_o        = rise_q;
    assign fall_o        = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Switch input conditioner: per-bit synchronise + debounce, edge pulses and a
// valid/ready change event carrying a snapshot of the debounced switch word.
// Ports:
//   sysclk      - system clock, rising edge
//   rst         - synchronous active-high reset
//   sw          - raw switch pins
//   sw_stable   - debounced levels
//   sw_rise     - one-cycle pulse per bit on accepted 0->1
//   sw_fall     - one-cycle pulse per bit on accepted 1->0
//   evt_valid   - change event pending
//   evt_data    - sw_stable snapshot for the pending event
//   evt_ready   - consumer accepts when high with evt_valid
//   evt_overrun - sticky: an unaccepted event was overwritten
module sw_debounce
    import panel_pkg::*;
#(
    parameter int unsigned WIDTH           = SW_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ready,
    output logic             evt_overrun
);

    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] update;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .sysclk       (sysclk),
            .rst          (rst),
            .sw_i         (sw[i]),
            .stable_o     (sw_stable[i]),
            .stable_next_o(stable_next[i]),
            .update_o     (update[i]),
            .rise_o       (sw_rise[i]),
            .fall_o       (sw_fall[i])
        );
    end

    logic             evt_valid_q, evt_valid_d;
    logic [WIDTH-1:0] evt_data_q, evt_data_d;
    logic             evt_overrun_q, evt_overrun_d;
    logic             accept;
    logic             change;

    always_comb begin
        accept        = evt_valid_q & evt_ready;
        change        = |update;
        evt_valid_d   = evt_valid_q;
        evt_data_d    = evt_data_q;
        evt_overrun_d = evt_overrun_q;
        if (change) begin
            // A change coalesces into the pending event; it only counts as an
            // overrun if the pending one is not being taken this cycle.
            evt_valid_d = 1'b1;
            evt_data_d  = stable_next;
            if (evt_valid_q && !accept) begin
                evt_overrun_d = 1'b1;
            end
        end else if (accept) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            evt_valid_q   <= 1'b0;
            evt_data_q    <= '0;
            evt_overrun_q <= 1'b0;
        end else begin
            evt_valid_q   <= evt_valid_d;
            evt_data_q    <= evt_data_d;
            evt_overrun_q <= evt_overrun_d;
        end
    end

    assign evt_valid   = evt_valid_q;
    assign evt_data    = evt_data_q;
    assign evt_overrun = evt_overrun_q;

endmodule

// File: tb/tb_sw_debounce.sv
// Bench for sw_debounce with WIDTH=2, DEBOUNCE_CYCLES=4. Directed stimulus
// pushes expected events into a queue; a monitor pops and compares on accept.
module tb_sw_debounce;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [1:0] sw;
    logic [1:0] sw_stable;
    logic [1:0] sw_rise;
    logic [1:0] sw_fall;
    logic       evt_valid;
    logic [1:0] evt_data;
    logic       evt_ready;
    logic       evt_overrun;

    typedef struct packed {
        logic [1:0] data;
        logic       ovr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 sysclk = ~sysclk;

    sw_debounce #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .sw         (sw),
        .sw_stable  (sw_stable),
        .sw_rise    (sw_rise),
        .sw_fall    (sw_fall),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic push(input logic [1:0] d, input logic o);
        exp_t e;
        e.data = d;
        e.ovr  = o;
        sb_q.push_back(e);
    endtask

    // Monitor: samples 2 ns after the falling edge, when inputs driven at the
    // falling edge have settled; an accept happens at the following rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge sysclk);
            #2;
            if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got event data %0b, expected none", evt_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_data", 32'(evt_data), 32'(e.data));
                    chk("sb_overrun", 32'(evt_overrun), 32'(e.ovr));
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        sw        = 2'b11;
        evt_ready = 1'b0;

        // Reset values with switches high
        tick(3);
        chk("rst_stable", 32'(sw_stable), 0);
        chk("rst_rise", 32'(sw_rise), 0);
        chk("rst_fall", 32'(sw_fall), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_data", 32'(evt_data), 0);
        chk("rst_overrun", 32'(evt_overrun), 0);
        rst = 1'b0;
        push(2'b11, 1'b0);
        tick(5);
        chk("rel_e5_stable", 32'(sw_stable), 0);
        chk("rel_e5_valid", 32'(evt_valid), 0);
        tick(1);
        chk("rel_e6_stable", 32'(sw_stable), 32'h3);
        chk("rel_e6_rise", 32'(sw_rise), 32'h3);
        chk("rel_e6_valid", 32'(evt_valid), 1);
        chk("rel_e6_data", 32'(evt_data), 32'h3);
        tick(1);
        chk("rel_e7_rise", 32'(sw_rise), 0);
        evt_ready = 1'b1;
        tick(1);
        chk("rel_accept_valid", 32'(evt_valid), 0);

        // Drop bit 0 so the clean-change rise can be observed
        sw = 2'b10;
        push(2'b10, 1'b0);
        tick(6);
        chk("fall_stable", 32'(sw_stable), 32'h2);
        chk("fall_pulse", 32'(sw_fall), 32'h1);
        tick(1);
        chk("fall_pulse_end", 32'(sw_fall), 0);

        // Clean change on bit 0 with evt_ready held high
        sw = 2'b11;
        push(2'b11, 1'b0);
        tick(5);
        chk("clean_e5_stable", 32'(sw_stable), 32'h2);
        chk("clean_e5_rise", 32'(sw_rise), 0);
        tick(1);
        chk("clean_e6_stable", 32'(sw_stable), 32'h3);
        chk("clean_e6_rise", 32'(sw_rise), 32'h1);
        chk("clean_e6_valid", 32'(evt_valid), 1);
        tick(1);
        chk("clean_e7_rise", 32'(sw_rise), 0);
        chk("clean_e7_valid", 32'(evt_valid), 0);

        // Bounce rejection on bit 1
        sw = 2'b01;
        push(2'b01, 1'b0);
        tick(8);
        chk("bounce_pre_stable", 32'(sw_stable), 32'h1);
        for (int i = 0; i < 4; i++) begin
            sw = {((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1};
            tick(1);
            chk("bounce_toggle_stable", 32'(sw_stable), 32'h1);
        end
        sw = 2'b11;
        push(2'b11, 1'b0);
        tick(5);
        chk("bounce_e5_stable", 32'(sw_stable), 32'h1);
        tick(1);
        chk("bounce_e6_stable", 32'(sw_stable), 32'h3);
        chk("bounce_e6_rise", 32'(sw_rise), 32'h2);
        tick(2);

        // Accept on the same edge a new change lands
        evt_ready = 1'b0;
        sw        = 2'b10;
        push(2'b10, 1'b0);
        tick(6);
        chk("simul_first_valid", 32'(evt_valid), 1);
        chk("simul_first_data", 32'(evt_data), 32'h2);
        sw = 2'b00;
        push(2'b00, 1'b0);
        tick(5);
        chk("simul_hold_data", 32'(evt_data), 32'h2);
        evt_ready = 1'b1;
        tick(1);
        chk("simul_valid", 32'(evt_valid), 1);
        chk("simul_data", 32'(evt_data), 32'h0);
        chk("simul_overrun", 32'(evt_overrun), 0);
        tick(1);
        chk("simul_after_valid", 32'(evt_valid), 0);

        // Coalesce and overrun with evt_ready low
        evt_ready = 1'b0;
        sw        = 2'b01;
        tick(6);
        chk("coal_first_valid", 32'(evt_valid), 1);
        chk("coal_first_data", 32'(evt_data), 32'h1);
        chk("coal_first_overrun", 32'(evt_overrun), 0);
        tick(4);
        sw = 2'b11;
        push(2'b11, 1'b1);
        tick(6);
        chk("coal_valid", 32'(evt_valid), 1);
        chk("coal_data", 32'(evt_data), 32'h3);
        chk("coal_overrun", 32'(evt_overrun), 1);
        evt_ready = 1'b1;
        tick(1);
        chk("coal_accept_valid", 32'(evt_valid), 0);
        chk("coal_sticky_overrun", 32'(evt_overrun), 1);

        // Reset in the middle of a count
        sw = 2'b01;
        tick(4);
        rst = 1'b1;
        tick(1);
        chk("mid_rst_stable", 32'(sw_stable), 0);
        chk("mid_rst_valid", 32'(evt_valid), 0);
        chk("mid_rst_data", 32'(evt_data), 0);
        chk("mid_rst_overrun", 32'(evt_overrun), 0);
        chk("mid_rst_pulses", 32'({sw_rise, sw_fall}), 0);
        tick(1);
        rst = 1'b0;
        push(2'b01, 1'b0);
        tick(5);
        chk("mid_e5_stable", 32'(sw_stable), 0);
        tick(1);
        chk("mid_e6_stable", 32'(sw_stable), 32'h1);
        chk("mid_e6_rise", 32'(sw_rise), 32'h1);
        chk("mid_e6_valid", 32'(evt_valid), 1);
        chk("mid_e6_data", 32'(evt_data), 32'h1);
        tick(2);
        chk("mid_after_valid", 32'(evt_valid), 0);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
